// File: rtl/lut_sweep_checker.sv
// ============================================================================
// Module   : lut_sweep_checker
// Brief    : Loadable truth-table evaluator with a DEPTH-stage result pipeline,
//            an exhaustive input sweep generator and a golden-table self-check.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lut_sweep_checker #(
    parameter int                        N_IN        = 3,
    parameter int                        DEPTH       = 2,
    parameter logic [(1 << N_IN)-1:0]    TRUTH_TABLE = 8'b01000011
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              load_en,
    input  logic              load_bit,
    input  logic              ext_valid,
    input  logic [N_IN-1:0]   ext_x,
    output logic              z_out,
    output logic              z_valid,
    output logic              error,
    output logic [15:0]       err_count,
    output logic              busy,
    output logic              done
);

    localparam int                 c_w      = 1 << N_IN;
    localparam int                 c_dw     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [N_IN:0]      c_last   = (N_IN+1)'(c_w - 1);
    localparam logic [c_w-1:0]     c_golden = TRUTH_TABLE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_w-1:0]    r_tbl;
    logic [N_IN:0]     r_cnt;
    logic [c_dw-1:0]   r_drain;
    logic [DEPTH-1:0]  r_v;
    logic [DEPTH-1:0]  r_z;
    logic [DEPTH-1:0]  r_e;
    logic [15:0]       r_err_count;
    logic              r_busy;
    logic              r_done;

    logic              w_inject;
    logic [N_IN-1:0]   w_x;
    logic              w_error;

    // start and load_en both outrank an external injection in IDLE
    assign w_inject = (r_state == S_SWEEP) ||
                      ((r_state == S_IDLE) && !start && !load_en && ext_valid);
    assign w_x      = (r_state == S_SWEEP) ? r_cnt[N_IN-1:0] : ext_x;
    assign w_error  = r_v[DEPTH-1] & (r_z[DEPTH-1] ^ r_e[DEPTH-1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_tbl       <= c_golden;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_err_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_error && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err_count <= '0;
                        r_cnt       <= '0;
                        r_state     <= S_SWEEP;
                    end else if (load_en) begin
                        r_tbl <= {load_bit, r_tbl[c_w-1:1]};
                    end
                end
                S_SWEEP: begin
                    r_busy <= 1'b1;
                    r_cnt  <= r_cnt + (N_IN+1)'(1);
                    if (r_cnt == c_last) begin
                        r_state <= S_DRAIN;
                        r_drain <= c_dw'(DEPTH - 1);
                    end
                end
                S_DRAIN: begin
                    // counts the stages the last sweep result still has to cross
                    if (r_drain == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - c_dw'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_v <= '0;
            r_z <= '0;
            r_e <= '0;
        end else begin
            r_v[0] <= w_inject;
            if (w_inject) begin
                r_z[0] <= r_tbl[w_x];
                r_e[0] <= c_golden[w_x];
            end
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k] <= r_v[k-1];
                if (r_v[k-1]) begin
                    r_z[k] <= r_z[k-1];
                    r_e[k] <= r_e[k-1];
                end
            end
        end
    end

    assign z_out     = r_z[DEPTH-1];
    assign z_valid   = r_v[DEPTH-1];
    assign error     = w_error;
    assign err_count = r_err_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lut_sweep_checker.sv
// ============================================================================
// Module   : tb_lut_sweep_checker
// Brief    : Timeline-model bench for lut_sweep_checker, two parameter sets.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lut_sweep_checker;

    localparam int MAXC = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    int n_tests = 0;
    int n_fail  = 0;

    logic rn0 = 1'b0, st0 = 1'b0, le0 = 1'b0, lb0 = 1'b0, ev0 = 1'b0;
    logic [2:0] ex0 = '0;
    logic z0, zv0, er0, bz0, dn0;
    logic [15:0] ec0;

    logic rn1 = 1'b0, st1 = 1'b0, le1 = 1'b0, lb1 = 1'b0, ev1 = 1'b0;
    logic [3:0] ex1 = '0;
    logic z1, zv1, er1, bz1, dn1;
    logic [15:0] ec1;

    lut_sweep_checker u_dut0 (
        .clock(clk), .reset_n(rn0), .start(st0), .load_en(le0), .load_bit(lb0),
        .ext_valid(ev0), .ext_x(ex0), .z_out(z0), .z_valid(zv0), .error(er0),
        .err_count(ec0), .busy(bz0), .done(dn0)
    );

    lut_sweep_checker #(.N_IN(4), .DEPTH(1), .TRUTH_TABLE(16'hA5C3)) u_dut1 (
        .clock(clk), .reset_n(rn1), .start(st1), .load_en(le1), .load_bit(lb1),
        .ext_valid(ev1), .ext_x(ex1), .z_out(z1), .z_valid(zv1), .error(er1),
        .err_count(ec1), .busy(bz1), .done(dn1)
    );

    // Expected outputs indexed by the edge after which they are visible
    bit          mv   [2][MAXC];
    bit          mz   [2][MAXC];
    bit          me   [2][MAXC];
    bit          mb   [2][MAXC];
    bit          md   [2][MAXC];
    bit          mclr [2][MAXC];
    logic [15:0] mtbl [2];
    logic [15:0] gold [2] = '{16'h0043, 16'hA5C3};
    int          wd   [2] = '{8, 16};
    int          dd   [2] = '{2, 1};
    int          done_edge [2];

    logic last_z [2];
    int   mcnt   [2];
    bit   pend   [2];

    logic qz0 [$];
    logic qer0 [$];
    int   qe0 [$];
    logic qz1 [$];
    int   qe1 [$];
    int   done_seen [2];
    int   ecd [2];

    task automatic chk(input string n, input int d, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %0h, expected %0h", n, d, edge_n, act, exp);
        end
    endtask

    function automatic void sched(int d, int c, int x);
        if (c < MAXC) begin
            mv[d][c] = 1'b1;
            mz[d][c] = mtbl[d][x];
            me[d][c] = (mtbl[d][x] != gold[d][x]);
        end
    endfunction

    function automatic void model_reset(int d);
        for (int c = edge_n; c < MAXC; c++) begin
            mv[d][c] = 0; mz[d][c] = 0; me[d][c] = 0;
            mb[d][c] = 0; md[d][c] = 0; mclr[d][c] = 0;
        end
        mtbl[d]      = gold[d];
        done_edge[d] = 0;
    endfunction

    // Apply the request sampled at edge e to the timeline
    function automatic void predict(int d, int e, logic rn, logic st, logic le,
                                    logic lb, logic ev, int x);
        if (!rn || e <= done_edge[d]) return;
        if (st) begin
            mclr[d][e] = 1'b1;
            for (int i = 0; i < wd[d]; i++) sched(d, e + i + dd[d], i);
            for (int c = e + 1; c < e + wd[d] + dd[d]; c++) mb[d][c] = 1'b1;
            md[d][e + wd[d] + dd[d]] = 1'b1;
            done_edge[d] = e + wd[d] + dd[d];
        end else if (le) begin
            for (int i = 0; i < wd[d] - 1; i++) mtbl[d][i] = mtbl[d][i+1];
            mtbl[d][wd[d]-1] = lb;
        end else if (ev) begin
            sched(d, e + dd[d] - 1, x);
        end
    endfunction

    task automatic cmp(input int d, input logic rn, input logic z, input logic zv,
                       input logic er, input logic [15:0] ec, input logic bz, input logic dn);
        int m;
        m = edge_n;
        if (m >= MAXC) return;
        if (!rn) begin
            last_z[d] = 1'b0; mcnt[d] = 0; pend[d] = 1'b0;
            chk("reset_outputs", d, {zv, z, er, bz, dn, ec}, 0);
        end else begin
            if (mclr[d][m]) mcnt[d] = 0;
            else if (pend[d] && mcnt[d] < 65535) mcnt[d]++;
            if (mv[d][m]) last_z[d] = mz[d][m];
            chk("z_valid", d, zv, mv[d][m]);
            chk("z_out", d, z, last_z[d]);
            chk("error", d, er, mv[d][m] && me[d][m]);
            chk("err_count", d, ec, mcnt[d]);
            chk("busy", d, bz, mb[d][m]);
            chk("done", d, dn, md[d][m]);
            pend[d] = mv[d][m] && me[d][m];
            if (zv) begin
                if (d == 0) begin qz0.push_back(z); qer0.push_back(er); qe0.push_back(m); end
                else begin qz1.push_back(z); qe1.push_back(m); end
            end
            if (dn) begin done_seen[d] = m; ecd[d] = ec; end
        end
    endtask

    always @(negedge clk) begin
        cmp(0, rn0, z0, zv0, er0, ec0, bz0, dn0);
        cmp(1, rn1, z1, zv1, er1, ec1, bz1, dn1);
    end

    task automatic cyc();
        predict(0, edge_n + 1, rn0, st0, le0, lb0, ev0, int'(ex0));
        predict(1, edge_n + 1, rn1, st1, le1, lb1, ev1, int'(ex1));
        @(posedge clk);
        #2;
        {st0, le0, lb0, ev0} = '0; ex0 = '0;
        {st1, le1, lb1, ev1} = '0; ex1 = '0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic clear_obs();
        qz0.delete(); qer0.delete(); qe0.delete(); qz1.delete(); qe1.delete();
        done_seen[0] = -1; done_seen[1] = -1; ecd[0] = -1; ecd[1] = -1;
    endtask

    task automatic chk_golden_sweep(input string n);
        logic [7:0] g;
        g = 8'b01000011;
        chk({n, "_len"}, 0, qz0.size(), 8);
        for (int i = 0; i < 8; i++) chk(n, 0, qz0[i], g[i]);
    endtask

    task automatic load_table(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            le0 = 1'b1; lb0 = bits[i];
            cyc();
        end
    endtask

    initial begin
        int s;
        int nerr;
        logic [15:0] t1;
        model_reset(0);
        model_reset(1);
        clear_obs();
        cycles(3);
        rn0 = 1'b1; rn1 = 1'b1;
        cycles(1);

        // Golden sweeps on both parameter sets
        clear_obs();
        s = edge_n + 1;
        st0 = 1'b1; st1 = 1'b1;
        cyc();
        cycles(20);
        chk_golden_sweep("sweep1_z");
        chk("sweep1_first_edge", 0, qe0[0], s + 2);
        chk("sweep1_done_edge", 0, done_seen[0], s + 10);
        chk("sweep1_errcnt", 0, ecd[0], 0);
        t1 = 16'hA5C3;
        chk("p2_len", 1, qz1.size(), 16);
        for (int i = 0; i < 16; i++) chk("p2_z", 1, qz1[i], t1[i]);
        chk("p2_first_edge", 1, qe1[0], s + 1);
        chk("p2_done_edge", 1, done_seen[1], s + 17);

        // Serially loaded table differing from golden at x=0
        load_table(8'b01000010);
        clear_obs();
        st0 = 1'b1;
        cyc();
        cycles(12);
        nerr = 0;
        foreach (qer0[i]) nerr += int'(qer0[i]);
        chk("load_err_x0", 0, qer0[0], 1);
        chk("load_err_total", 0, nerr, 1);
        chk("load_errcnt_done", 0, ecd[0], 1);

        // Back-to-back external injections
        load_table(8'b01000011);
        clear_obs();
        s = edge_n + 1;
        ev0 = 1'b1; ex0 = 3'd6; cyc();
        ev0 = 1'b1; ex0 = 3'd7; cyc();
        ev0 = 1'b1; ex0 = 3'd0; cyc();
        cycles(4);
        chk("ext_len", 0, qz0.size(), 3);
        chk("ext_z0", 0, qz0[0], 1);
        chk("ext_z1", 0, qz0[1], 0);
        chk("ext_z2", 0, qz0[2], 1);
        chk("ext_first_edge", 0, qe0[0], s + 1);
        chk("ext_last_edge", 0, qe0[2], s + 3);

        // Start with concurrent lower-priority requests, load_en held through the sweep
        clear_obs();
        st0 = 1'b1; le0 = 1'b1; lb0 = 1'b1; ev0 = 1'b1; ex0 = 3'd5;
        cyc();
        for (int i = 0; i < 10; i++) begin
            le0 = 1'b1; lb0 = 1'($urandom);
            cyc();
        end
        cycles(2);
        chk_golden_sweep("prio_z");
        chk("prio_errcnt", 0, ecd[0], 0);
        clear_obs();
        st0 = 1'b1;
        cyc();
        cycles(12);
        chk_golden_sweep("prio2_z");
        chk("prio2_errcnt", 0, ecd[0], 0);

        // Reset after the third sweep injection
        clear_obs();
        st0 = 1'b1;
        cyc();
        cycles(3);
        rn0 = 1'b0;
        model_reset(0);
        #1;
        chk("abort_outputs", 0, {zv0, z0, er0, bz0, dn0, ec0}, 0);
        cycles(3);
        chk("abort_no_done", 0, done_seen[0], -1);
        rn0 = 1'b1;
        cycles(1);
        clear_obs();
        st0 = 1'b1;
        cyc();
        cycles(12);
        chk_golden_sweep("post_abort_z");
        chk("post_abort_errcnt", 0, ecd[0], 0);

        // Randomised traffic on both instances
        for (int i = 0; i < 300; i++) begin
            st0 = ($urandom_range(0, 39) == 0); le0 = ($urandom_range(0, 3) == 0);
            lb0 = 1'($urandom); ev0 = 1'($urandom); ex0 = 3'($urandom);
            st1 = ($urandom_range(0, 39) == 0); le1 = ($urandom_range(0, 3) == 0);
            lb1 = 1'($urandom); ev1 = 1'($urandom); ex1 = 4'($urandom);
            cyc();
        end
        cycles(25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_sweep_checker.md
# lut_sweep_checker

Clocked, parametrised truth-table evaluator with built-in self-check. Evaluates an N_IN-input Boolean function held in a run-time-loadable lookup register and passes the result through a DEPTH-stage register pipeline. Every result is compared against the golden TRUTH_TABLE, and mismatches are counted. An internal sweep generator drives all 2^N_IN input vectors, so the block serves as the clocked, self-checking successor to the lab's combinational function blocks.

## Interface
- N_IN, 3, number of function inputs (1..8); table width W = 2^N_IN.
- DEPTH, 2, pipeline stages from input sample to output (≥1).
- TRUTH_TABLE, 8'b01000011 (W bits), golden function; bit i = f(x=i); also the lookup-register reset value.

- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  sampled in IDLE: begin exhaustive sweep.
- load_en  in  1  sampled in IDLE: shift load_bit into lookup register.
- load_bit  in  1  serial table data.
- ext_valid  in  1  sampled in IDLE: inject ext_x into pipeline.
- ext_x  in  N_IN  external input vector.
- z_out  out  1  function value from last stage.
- z_valid  out  1  z_out/error valid this cycle.
- error  out  1  z_out ≠ golden for this result (0 when z_valid=0).
- err_count  out  16  saturating mismatch count.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle sweep-complete pulse.

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE, priority start > load_en > ext_valid; lower-priority requests in the same cycle are dropped.
  - start: clear err_count, clear sweep counter, go SWEEP.
  - load_en: tbl <= {load_bit, tbl[W-1:1]}. After W loads, the first bit loaded sits at tbl[0].
  - ext_valid: inject ext_x into stage 1.
- SWEEP: each cycle, inject x = counter and increment counter. After injecting x = W-1, go DRAIN. start, load_en and ext_valid are ignored.
- DRAIN: wait until the final sweep result has left stage DEPTH, then go IDLE and pulse done. Inputs are ignored.
- Injection into stage 1 captures x, z = tbl[x], exp = TRUTH_TABLE[x], and v = 1.
  - Non-injecting cycles write v = 0 into stage 1.
  - Valid bits shift every cycle.
  - Data registers load only when the upstream valid bit is 1, so z_out holds the last valid result.
- tbl is read at injection time; later loads do not affect results already in flight.
- Output mapping:
  - z_valid = v of stage DEPTH.
  - error = z_valid & (z ≠ exp).
  - err_count increments by 1 per cycle with error = 1, saturating at 16'hFFFF. External-mode mismatches are counted too.
- busy = 1 in SWEEP and DRAIN; busy = 0 in the done cycle.

## Timing
- Reset (async assert, sync release):
  - state IDLE, tbl = TRUTH_TABLE, counter = 0.
  - All stage valid bits 0.
  - z_out = 0, z_valid = 0, error = 0, err_count = 0, busy = 0, done = 0.
- Latency: input sampled at edge t is visible on outputs after edge t+DEPTH-1. For DEPTH=1, outputs update on the sampling edge itself.
- Throughput: one result per cycle; back-to-back ext_valid is supported with no bubbles.
- Sweep, with start sampled at edge 0:
  - injections at edges 1..W;
  - z_valid high after edges DEPTH..W+DEPTH-1;
  - done high for exactly one cycle after edge W+DEPTH;
  - busy high after edges 1..W+DEPTH-1.
- Sweep counter is N_IN+1 bits internally; x = counter[N_IN-1:0]. There is no wrap during a sweep.
- err_count is cleared at the start edge. Results still draining from earlier external injections at that edge are lost.
- Reset mid-sweep aborts immediately: no done, tbl restored to TRUTH_TABLE.

## Test plan
- Default params, reset, then start pulse:
  - z_out for x=0..7 reads 1,1,0,0,0,0,1,0 on consecutive z_valid cycles (first after edge 2);
  - error always 0, err_count = 0;
  - done for one cycle after edge 10.
- Serial-load bits 0,1,0,0,0,0,1,0 (LSB first, i.e. table 8'b01000010), then sweep:
  - error = 1 only on the x=0 result;
  - err_count = 1 at done.
- IDLE ext_valid with ext_x = 6, 7, 0 on back-to-back cycles:
  - z_valid high for 3 consecutive cycles starting after edge t+1;
  - z_out reads 1, 0, 1.
- Same-cycle start + load_en + ext_valid:
  - sweep starts; table is unchanged; no extra result appears.
  - load_en held through the sweep also leaves tbl unchanged, confirmed by a second sweep with err_count = 0.
- Assert reset_n low after the third sweep injection:
  - all outputs 0 immediately, no done pulse;
  - a following sweep matches the golden sequence.
- N_IN=4, DEPTH=1, TRUTH_TABLE = 16'hA5C3:
  - sweep yields 16 results matching the table bits, first result after edge 1;
  - done after edge 17.
